// File: rtl/fpga_sram_out_reg.sv
// Enable-gated output register with synchronous active-high clear.
// Used for the data-registered read stage and the optional output pipeline stage.
module fpga_sram_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_q;

  // Clear takes priority over the load enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= {DATA_WIDTH{1'b0}};
    end else if (i_en) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fpga_sram.sv
// Inferable single-port synchronous RAM with per-lane write enables for FPGA builds.
// Optional macro FPGA_SRAM_ZERO_INIT_EN gives the array an all-zero initial value.
module fpga_sram #(
  parameter int MEM_SIZE   = 1,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_MSB   = 0,
  parameter int ADDR_LSB   = 0,
  parameter int WR_SIZE    = 8,
  parameter bit SYNC_OUT   = 1'b1,
  parameter bit PIPELINED  = 1'b0,
  parameter     RAM_STL    = "block"
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic [ADDR_MSB:ADDR_LSB]         addr,
  input  logic                             regen,
  input  logic                             rden,
  input  logic [DATA_WIDTH/WR_SIZE-1:0]    wren,
  output logic [DATA_WIDTH-1:0]            dout
);

  localparam int NLANES = DATA_WIDTH / WR_SIZE;
  localparam int IW     = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

`ifdef FPGA_SRAM_ZERO_INIT_EN
  (* ram_style = RAM_STL *) logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE] = '{default: {DATA_WIDTH{1'b0}}};
`else
  (* ram_style = RAM_STL *) logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];
`endif

  logic [IW-1:0]         w_widx;
  logic                  w_wr_ok;
  logic [DATA_WIDTH-1:0] w_read_path;

  function automatic logic in_range(input logic [ADDR_MSB:ADDR_LSB] a);
    return (32'(a) < 32'(MEM_SIZE));
  endfunction

  assign w_widx  = IW'(addr);
  assign w_wr_ok = in_range(addr);

  // Lane-merged write; out-of-range indices must not alias onto real words.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int i = 0; i < NLANES; i++) begin
        if (wren[i]) begin
          r_mem[w_widx][i*WR_SIZE +: WR_SIZE] <= din[i*WR_SIZE +: WR_SIZE];
        end
      end
    end
  end

  generate
    if (SYNC_OUT) begin : g_data_reg
      logic [DATA_WIDTH-1:0] w_rd_cur;

      assign w_rd_cur = w_wr_ok ? r_mem[w_widx] : {DATA_WIDTH{1'b0}};

      fpga_sram_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_dout_q (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (rden),
        .i_d   (w_rd_cur),
        .o_q   (w_read_path)
      );
    end else begin : g_addr_reg
      logic [ADDR_MSB:ADDR_LSB] r_addr_q;

      // Registered read address; the array is then read combinationally.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_addr_q <= {(ADDR_MSB-ADDR_LSB+1){1'b0}};
        end else if (rden) begin
          r_addr_q <= addr;
        end else begin
          r_addr_q <= r_addr_q;
        end
      end

      assign w_read_path = in_range(r_addr_q) ? r_mem[IW'(r_addr_q)] : {DATA_WIDTH{1'b0}};
    end
  endgenerate

  generate
    if (PIPELINED) begin : g_pipe
      fpga_sram_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_pipe_q (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (regen),
        .i_d   (w_read_path),
        .o_q   (dout)
      );
    end else begin : g_no_pipe
      logic w_unused_regen;
      assign w_unused_regen = regen;
      assign dout           = w_read_path;
    end
  endgenerate

endmodule

// File: tb/tb_fpga_sram.sv
// Directed bench: three fpga_sram builds (data-registered, address-registered,
// data-registered + pipelined) share one stimulus stream with hand-computed results.
module tb_fpga_sram;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic [4:0]  addr;
  logic        regen;
  logic        rden;
  logic [3:0]  wren;
  logic [31:0] d_sync;
  logic [31:0] d_async;
  logic [31:0] d_pipe;

  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fpga_sram #(.MEM_SIZE(16), .DATA_WIDTH(32), .ADDR_MSB(4), .ADDR_LSB(0), .WR_SIZE(8),
              .SYNC_OUT(1'b1), .PIPELINED(1'b0)) u_sync (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .regen(regen),
    .rden(rden), .wren(wren), .dout(d_sync));

  fpga_sram #(.MEM_SIZE(16), .DATA_WIDTH(32), .ADDR_MSB(4), .ADDR_LSB(0), .WR_SIZE(8),
              .SYNC_OUT(1'b0), .PIPELINED(1'b0)) u_async (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .regen(regen),
    .rden(rden), .wren(wren), .dout(d_async));

  fpga_sram #(.MEM_SIZE(16), .DATA_WIDTH(32), .ADDR_MSB(4), .ADDR_LSB(0), .WR_SIZE(8),
              .SYNC_OUT(1'b1), .PIPELINED(1'b1)) u_pipe (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .regen(regen),
    .rden(rden), .wren(wren), .dout(d_pipe));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it, and settle just past the edge.
  task automatic step(input logic s_rst, input logic [4:0] s_addr, input logic [31:0] s_din,
                      input logic [3:0] s_wren, input logic s_rden, input logic s_regen);
    rst   = s_rst;
    addr  = s_addr;
    din   = s_din;
    wren  = s_wren;
    rden  = s_rden;
    regen = s_regen;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0; addr = 5'd0; din = 32'h0; wren = 4'h0; rden = 1'b0; regen = 1'b0;
    #2;

    // Reset cycle also writes word 0.
    step(1'b1, 5'd0, 32'h0BADF00D, 4'hF, 1'b0, 1'b0);
    check_eq("rst_sync",  d_sync,  32'h0);
    check_eq("rst_pipe",  d_pipe,  32'h0);
    check_eq("rst_async_mem0", d_async, 32'h0BADF00D);

    step(1'b0, 5'd3, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    check_eq("wr_no_rd_sync", d_sync, 32'h0);

    step(1'b0, 5'd3, 32'h0, 4'h0, 1'b1, 1'b1);
    check_eq("rd3_sync",  d_sync,  32'hDEADBEEF);
    check_eq("rd3_async", d_async, 32'hDEADBEEF);
    check_eq("rd3_pipe_lat1", d_pipe, 32'h0);

    step(1'b0, 5'd9, 32'h0, 4'h0, 1'b0, 1'b1);
    check_eq("hold_sync", d_sync, 32'hDEADBEEF);
    check_eq("hold_async", d_async, 32'hDEADBEEF);
    check_eq("rd3_pipe_lat2", d_pipe, 32'hDEADBEEF);

    step(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 1'b0);
    check_eq("rd0_sync", d_sync, 32'h0BADF00D);
    check_eq("regen0_pipe_hold", d_pipe, 32'hDEADBEEF);

    step(1'b0, 5'd3, 32'h11223344, 4'b0101, 1'b0, 1'b0);
    step(1'b0, 5'd3, 32'h0, 4'h0, 1'b1, 1'b1);
    check_eq("partial_sync", d_sync, 32'hDE22BE44);
    check_eq("partial_async", d_async, 32'hDE22BE44);
    check_eq("pipe_prev", d_pipe, 32'h0BADF00D);
    step(1'b0, 5'd3, 32'h0, 4'h0, 1'b0, 1'b1);
    check_eq("partial_pipe", d_pipe, 32'hDE22BE44);

    // Same-address read and write.
    step(1'b0, 5'd5, 32'h0, 4'hF, 1'b0, 1'b0);
    step(1'b0, 5'd5, 32'hAAAA5555, 4'hF, 1'b1, 1'b0);
    check_eq("rbw_sync_old", d_sync, 32'h0);
    check_eq("rw_async_new", d_async, 32'hAAAA5555);
    step(1'b0, 5'd5, 32'h0, 4'h0, 1'b1, 1'b0);
    check_eq("rbw_sync_next", d_sync, 32'hAAAA5555);

    // Address-registered view picks up a later write to the held address.
    step(1'b0, 5'd7, 32'h0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 5'd7, 32'h12345678, 4'hF, 1'b0, 1'b0);
    check_eq("async_wr_visible", d_async, 32'h12345678);
    step(1'b0, 5'd2, 32'h0, 4'h0, 1'b0, 1'b0);
    check_eq("async_addr_hold", d_async, 32'h12345678);

    // Out-of-range index 20 must neither read data nor alias onto word 4.
    step(1'b0, 5'd4, 32'h44444444, 4'hF, 1'b0, 1'b0);
    step(1'b0, 5'd20, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
    check_eq("oor_sync", d_sync, 32'h0);
    check_eq("oor_async", d_async, 32'h0);
    step(1'b0, 5'd4, 32'h0, 4'h0, 1'b1, 1'b0);
    check_eq("no_alias_sync", d_sync, 32'h44444444);
    check_eq("no_alias_async", d_async, 32'h44444444);
    check_eq("pipe_long_hold", d_pipe, 32'hDE22BE44);

    // Reset beats rden/regen; memory survives.
    step(1'b0, 5'd3, 32'h0, 4'h0, 1'b1, 1'b0);
    check_eq("pre_rst_sync", d_sync, 32'hDE22BE44);
    step(1'b1, 5'd5, 32'h0, 4'h0, 1'b1, 1'b1);
    check_eq("rst2_sync", d_sync, 32'h0);
    check_eq("rst2_pipe", d_pipe, 32'h0);
    check_eq("rst2_async_mem0", d_async, 32'h0BADF00D);
    step(1'b0, 5'd3, 32'h0, 4'h0, 1'b1, 1'b1);
    check_eq("post_rst_sync", d_sync, 32'hDE22BE44);
    step(1'b0, 5'd3, 32'h0, 4'h0, 1'b0, 1'b1);
    check_eq("post_rst_pipe", d_pipe, 32'hDE22BE44);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpga_sram.md
Name: fpga_sram

Overview:
- Inferable single-port synchronous RAM for FPGA builds; the FPGA substitute for ASIC SRAM macros such as the SCM data-bank wrapper.
- Write enables are per lane, WR_SIZE bits per lane.
- Read data is either address-registered (SYNC_OUT=0) or data-registered (SYNC_OUT=1), with an optional extra output pipeline stage.

Parameters:
- MEM_SIZE, default 1: number of words.
- DATA_WIDTH, default 8: word width in bits.
- ADDR_MSB, default 0: MSB index of the addr port.
- ADDR_LSB, default 0: LSB index of the addr port. The word index is the value of addr[ADDR_MSB:ADDR_LSB].
- WR_SIZE, default 8: bits per write lane. DATA_WIDTH must be a multiple of WR_SIZE.
- SYNC_OUT, default 1'b1: 1 registers read data; 0 registers the read address.
- PIPELINED, default 1'b0: 1 adds an output register gated by regen.
- RAM_STL, default "block": string passed to the synthesis ram_style attribute (e.g. "no_rw_check"). No functional effect.
- Localparam NLANES = DATA_WIDTH/WR_SIZE.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high; clears output-path registers only.
- din  in  DATA_WIDTH  write data.
- addr  in  ADDR_MSB-ADDR_LSB+1  word address for read and write.
- regen  in  1  output pipeline register enable (used only when PIPELINED=1).
- rden  in  1  read enable.
- wren  in  NLANES  per-lane write enable; bit i covers din[i*WR_SIZE +: WR_SIZE].
- dout  out  DATA_WIDTH  read data.

Behaviour:
- Write:
  - At a rising clk edge, for each lane i with wren[i]=1, mem[addr] lane i <= din lane i.
  - Lanes with wren[i]=0 are unchanged.
  - There is no separate global write enable; wren=0 means no write.
- Read, SYNC_OUT=1:
  - At an edge with rden=1, dout_q <= mem[addr], using pre-write contents (read-before-write).
  - dout_q holds when rden=0.
  - Latency is 1 cycle.
- Read, SYNC_OUT=0:
  - At an edge with rden=1, addr_q <= addr.
  - The read path is combinational: mem[addr_q].
  - A write to addr_q becomes visible on dout in the cycle after that write.
  - Latency is 1 cycle.
- PIPELINED=1:
  - At an edge with regen=1, pipe_q <= the read path; dout = pipe_q.
  - Total latency is 2 cycles when regen is held high.
- PIPELINED=0: dout is the read path directly; regen is ignored.
- Reset (rst=1 at an edge):
  - dout_q, pipe_q and addr_q go to 0.
  - Reset takes priority over rden and regen in that cycle.
  - Memory contents are not affected, and a write in the reset cycle still occurs.
- Output after reset:
  - SYNC_OUT=1 or PIPELINED=1: dout=0.
  - SYNC_OUT=0, PIPELINED=0: dout=mem[0].
- Out-of-range address (index >= MEM_SIZE): writes are ignored; reads return 0.
- Simultaneous read and write at the same address:
  - SYNC_OUT=1 returns old data.
  - SYNC_OUT=0 shows new data from the next cycle.
- Partial-lane writes merge with existing data.
- No handshakes; the block is always ready.

Optional Feature:
- Macro FPGA_SRAM_ZERO_INIT_EN.
  - Defined: all MEM_SIZE words are initialised to 0 at time zero. This is synthesised as a RAM init value.
  - Undefined: contents are uninitialised (X in simulation) until written.

Decomposition:
- No shared package is needed; NLANES and the read-path mux stay as local parameters and logic.
- One natural sub-module: fpga_sram_out_reg. It is a DATA_WIDTH enable-gated register with synchronous reset, instantiated for dout_q (enable rden) and pipe_q (enable regen).
- Keep the memory array in the top so the synthesis tool infers block RAM.

Test Plan:
All scenarios use MEM_SIZE=16, DATA_WIDTH=32, WR_SIZE=8 unless stated.
- SYNC_OUT=1, PIPELINED=0:
  - Write addr 3 = 0xDEADBEEF with wren=4'hF, then rden at addr 3 -> dout=0xDEADBEEF one cycle after the read edge.
  - Then hold rden=0 and change addr -> dout stays 0xDEADBEEF.
- Partial write: wren=4'b0101, din=0x11223344 to addr 3 (holding 0xDEADBEEF), then read -> dout=0xDE22BE44.
- SYNC_OUT=1: write 0xAAAA5555 and read addr 5 in the same cycle (old 0x0) -> dout=0x0; the next read returns 0xAAAA5555.
- SYNC_OUT=0: rden at addr 7, then write 0x12345678 to addr 7 with rden=0 -> dout shows 0x12345678 the cycle after the write.
- PIPELINED=1, SYNC_OUT=1:
  - Read addr 3 with regen=1 -> data appears on dout 2 cycles later.
  - With regen=0, dout holds its previous value.
- Reset: assert rst for one edge while dout=0xDE22BE44 -> dout=0 (SYNC_OUT=1); memory is retained, and re-reading addr 3 returns 0xDE22BE44.
